// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control / RV32M multiply-divide block.
package alu_ctrl_pkg;

    // Instruction class supplied by the main control unit
    typedef enum logic [2:0] {
        ALUOP_R   = 3'b000,
        ALUOP_I   = 3'b001,
        ALUOP_LUI = 3'b010,
        ALUOP_MEM = 3'b011,
        ALUOP_BR  = 3'b100
    } alu_op_e;

    // Operation codes understood by the ALU
    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_code_e;

    // funct3 selection inside the M extension
    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } m_f3_e;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    // funct7 value that marks an R-type instruction as an M-extension op
    localparam logic [6:0] M_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/md_iter_core.sv
// Iterative unsigned datapath: shift-add multiply (K bits per step) and
// restoring divide (1 bit per step). Operands are magnitudes; sign handling
// is done by the caller. The *_next outputs are the values after the
// current step so the caller can register the final result on the last step.
module md_iter_core #(
    parameter int W = 32,
    parameter int K = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           step,
    input  logic           is_div,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic [2*W-1:0] prod_next,
    output logic [W-1:0]   quo_next,
    output logic [W-1:0]   rem_next
);

    // acc_r: product accumulator (mul) or partial remainder in the low half (div)
    // mcand_r: left-shifting multiplicand (mul) or divisor in the low half (div)
    // x_r: right-shifting multiplier (mul) or dividend/quotient (div)
    logic [2*W-1:0] acc_r;
    logic [2*W-1:0] mcand_r;
    logic [W-1:0]   x_r;
    logic           div_mode_r;

    logic [2*W-1:0] partial_s;
    logic [W:0]     shifted_s;
    logic [W:0]     diff_s;
    logic           q_bit_s;

    // Multiply step: add multiplicand for each of the K low multiplier bits
    always_comb begin
        partial_s = '0;
        for (int i = 0; i < K; i++) begin
            partial_s = partial_s + (x_r[i] ? (mcand_r << i) : {(2*W){1'b0}});
        end
        prod_next = acc_r + partial_s;
    end

    // Restoring divide step: shift in next dividend bit, trial-subtract divisor
    always_comb begin
        shifted_s = {acc_r[W-1:0], x_r[W-1]};
        diff_s    = shifted_s - {1'b0, mcand_r[W-1:0]};
        if (diff_s[W]) begin
            q_bit_s  = 1'b0;
            rem_next = shifted_s[W-1:0];
        end else begin
            q_bit_s  = 1'b1;
            rem_next = diff_s[W-1:0];
        end
        quo_next = {x_r[W-2:0], q_bit_s};
    end

    // Datapath registers: load on start, advance one iteration per step
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_r      <= '0;
            mcand_r    <= '0;
            x_r        <= '0;
            div_mode_r <= 1'b0;
        end else if (start) begin
            acc_r      <= '0;
            x_r        <= is_div ? op_a : op_b;
            mcand_r    <= {{W{1'b0}}, (is_div ? op_b : op_a)};
            div_mode_r <= is_div;
        end else if (step) begin
            if (div_mode_r) begin
                acc_r <= {{W{1'b0}}, rem_next};
                x_r   <= quo_next;
            end else begin
                acc_r   <= prod_next;
                mcand_r <= mcand_r << K;
                x_r     <= x_r >> K;
            end
        end
    end

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decode (combinational) plus RV32M multiply/divide sequencer
// that stalls the pipeline and supplies its own writeback result.
module alu_control_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [6:0]            funct7_i,
    input  logic [2:0]            ALU_Op_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    output logic [3:0]            ALU_Operation_o,
    output logic                  stall_o,
    output logic                  md_sel_o,
    output logic [DATA_WIDTH-1:0] md_result_o,
    output logic                  md_valid_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] MUL_ITERS = CW'(W / MUL_BITS_PER_CYCLE);
    localparam logic [CW-1:0] DIV_ITERS = CW'(W);
    localparam logic [W-1:0]  MIN_VAL   = {1'b1, {(W-1){1'b0}}};

    alu_code_e      alu_code_s;
    logic           is_r_s, r_alt_s, is_m_s;
    logic           a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [W-1:0]   mag_a_s, mag_b_s;
    logic           div_zero_s, ovf_s, fast_s;
    logic [W-1:0]   fast_res_s;
    logic           start_s, step_s;
    logic [2*W-1:0] prod_next_s, prod_fix_s;
    logic [W-1:0]   quo_next_s, rem_next_s, quo_fix_s, rem_fix_s, final_s;

    md_state_e      state_r, next_state_s;
    logic [CW-1:0]  count_r;
    logic [2:0]     f3_r;
    logic           neg_q_r, neg_r_r;

    assign is_r_s  = (ALU_Op_i == ALUOP_R);
    assign r_alt_s = is_r_s & funct7_i[5];
    assign is_m_s  = valid_i & is_r_s & (funct7_i == M_FUNCT7);

    // ALU operation decode; funct7[5] only matters for R-type SUB/SRA and shift-right
    always_comb begin
        alu_code_s = ALU_ADD;
        case (ALU_Op_i)
            ALUOP_R, ALUOP_I: begin
                case (funct3_i)
                    3'b000:  alu_code_s = r_alt_s ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_code_s = r_alt_s ? ALU_ADD : ALU_SLL;
                    3'b010:  alu_code_s = r_alt_s ? ALU_ADD : ALU_SLT;
                    3'b011:  alu_code_s = r_alt_s ? ALU_ADD : ALU_SLTU;
                    3'b100:  alu_code_s = r_alt_s ? ALU_ADD : ALU_XOR;
                    3'b101:  alu_code_s = funct7_i[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_code_s = r_alt_s ? ALU_ADD : ALU_OR;
                    3'b111:  alu_code_s = r_alt_s ? ALU_ADD : ALU_AND;
                    default: alu_code_s = ALU_ADD;
                endcase
            end
            ALUOP_LUI: alu_code_s = ALU_PASSB;
            ALUOP_MEM: alu_code_s = ALU_ADD;
            ALUOP_BR:  alu_code_s = ALU_SUB;
            default:   alu_code_s = ALU_ADD;
        endcase
    end

    assign ALU_Operation_o = alu_code_s;

    // Operand sign flags and magnitudes for the unsigned iterative core
    always_comb begin
        a_signed_s = (funct3_i == M_MULH) | (funct3_i == M_MULHSU) |
                     (funct3_i == M_DIV)  | (funct3_i == M_REM);
        b_signed_s = (funct3_i == M_MULH) | (funct3_i == M_DIV) | (funct3_i == M_REM);
        a_neg_s    = a_signed_s & rs1_data_i[W-1];
        b_neg_s    = b_signed_s & rs2_data_i[W-1];
        mag_a_s    = a_neg_s ? (-rs1_data_i) : rs1_data_i;
        mag_b_s    = b_neg_s ? (-rs2_data_i) : rs2_data_i;
    end

    // Fast-path detection and its fixed result (divide by zero, MIN / -1)
    always_comb begin
        div_zero_s = funct3_i[2] & (rs2_data_i == {W{1'b0}});
        ovf_s      = ((funct3_i == M_DIV) | (funct3_i == M_REM)) &
                     (rs1_data_i == MIN_VAL) & (rs2_data_i == {W{1'b1}});
        fast_s     = div_zero_s | ovf_s;
        if (div_zero_s) begin
            fast_res_s = funct3_i[1] ? rs1_data_i : {W{1'b1}};
        end else begin
            fast_res_s = funct3_i[1] ? {W{1'b0}} : MIN_VAL;
        end
    end

    assign start_s = (state_r == ST_IDLE) & is_m_s & ~fast_s;
    assign step_s  = (state_r == ST_BUSY) & valid_i;

    md_iter_core #(
        .W (W),
        .K (MUL_BITS_PER_CYCLE)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .start     (start_s),
        .step      (step_s),
        .is_div    (funct3_i[2]),
        .op_a      (mag_a_s),
        .op_b      (mag_b_s),
        .prod_next (prod_next_s),
        .quo_next  (quo_next_s),
        .rem_next  (rem_next_s)
    );

    // Sign correction and result selection for the last iteration
    always_comb begin
        prod_fix_s = neg_q_r ? (-prod_next_s) : prod_next_s;
        quo_fix_s  = neg_q_r ? (-quo_next_s) : quo_next_s;
        rem_fix_s  = neg_r_r ? (-rem_next_s) : rem_next_s;
        if (f3_r[2]) begin
            final_s = f3_r[1] ? rem_fix_s : quo_fix_s;
        end else begin
            final_s = (f3_r == M_MUL) ? prod_fix_s[W-1:0] : prod_fix_s[2*W-1:W];
        end
    end

    // Sequencer next-state and handshake outputs
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (is_m_s) begin
                    next_state_s = fast_s ? ST_DONE : ST_BUSY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!valid_i) begin
                    next_state_s = ST_IDLE;
                end else if (count_r == CW'(1)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
        stall_o    = reset & is_m_s & (state_r != ST_DONE);
        md_valid_o = (state_r == ST_DONE);
        md_sel_o   = (state_r == ST_DONE);
    end

    // State, iteration counter, captured op info and the result register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            count_r     <= '0;
            f3_r        <= 3'b000;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            md_result_o <= '0;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                ST_IDLE: begin
                    if (is_m_s) begin
                        f3_r    <= funct3_i;
                        neg_q_r <= a_neg_s ^ b_neg_s;
                        neg_r_r <= a_neg_s;
                        if (fast_s) begin
                            md_result_o <= fast_res_s;
                            count_r     <= '0;
                        end else begin
                            count_r <= funct3_i[2] ? DIV_ITERS : MUL_ITERS;
                        end
                    end
                end
                ST_BUSY: begin
                    if (valid_i) begin
                        count_r <= count_r - CW'(1);
                        if (count_r == CW'(1)) begin
                            md_result_o <= final_s;
                        end
                    end else begin
                        count_r <= '0;
                    end
                end
                default: count_r <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Self-checking bench for alu_control_mdu: directed and randomized decode and
// M-extension operations checked against a plain-arithmetic reference model.
module tb_alu_control_mdu;

    localparam int W = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset, v1, v4;
    logic [6:0]  funct7;
    logic [2:0]  alu_op, funct3;
    logic [31:0] rs1, rs2;
    logic [3:0]  op1, op4;
    logic        stall1, stall4, sel1, sel4, mv1, mv4;
    logic [31:0] res1, res4;

    int checks = 0;
    int failures = 0;

    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    int          pulses;

    always #5 clk = ~clk;

    alu_control_mdu #(.DATA_WIDTH(32), .MUL_BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .valid_i(v1), .funct7_i(funct7), .ALU_Op_i(alu_op),
        .funct3_i(funct3), .rs1_data_i(rs1), .rs2_data_i(rs2), .ALU_Operation_o(op1),
        .stall_o(stall1), .md_sel_o(sel1), .md_result_o(res1), .md_valid_o(mv1));

    alu_control_mdu #(.DATA_WIDTH(32), .MUL_BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .valid_i(v4), .funct7_i(funct7), .ALU_Op_i(alu_op),
        .funct3_i(funct3), .rs1_data_i(rs1), .rs2_data_i(rs2), .ALU_Operation_o(op4),
        .stall_o(stall4), .md_sel_o(sel4), .md_result_o(res4), .md_valid_o(mv4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode from the instruction-class rules
    function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [6:0] f7,
                                           input logic [2:0] f3);
        logic [3:0] tbl [8];
        tbl = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h4, 4'h6, 4'h3, 4'h2};
        if (op == 3'd0) begin
            if (!f7[5]) return tbl[f3];
            if (f3 == 3'd0) return 4'h1;
            if (f3 == 3'd5) return 4'h7;
            return 4'h0;
        end
        if (op == 3'd1) return (f3 == 3'd5 && f7[5]) ? 4'h7 : tbl[f3];
        if (op == 3'd2) return 4'hA;
        if (op == 3'd4) return 4'h1;
        return 4'h0;
    endfunction

    // Reference M-extension result using wide native arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint     sa, sb;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = int'(a);
        ib = int'(b);
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Expected stall cycles: accept cycle plus iteration cycles (none on fast path)
    function automatic int exp_stall(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b, input int k);
        if (f3[2]) begin
            if (b == 0 || ((f3 == 3'd4 || f3 == 3'd6) && a == MIN && b == 32'hFFFF_FFFF))
                return 1;
            return W + 1;
        end
        return W / k + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN;
            3:       return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    task automatic dec(input logic [2:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [3:0] exp, input string tag);
        @(negedge clk);
        alu_op = op; funct7 = f7; funct3 = f3; v1 = 1'b1;
        #1;
        chk({tag, " dut1 op"}, 32'(op1), 32'(exp));
        chk({tag, " dut4 op"}, 32'(op4), 32'(exp));
        chk({tag, " stall"}, 32'(stall1), 32'd0);
    endtask

    task automatic run_m(input bit use4, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input string tag);
        int          stalls;
        bit          done;
        logic [31:0] got;
        logic        sel_seen;
        int          exp_st;
        exp_st = exp_stall(f3, a, b, use4 ? 4 : 1);
        @(negedge clk);
        alu_op = 3'b000; funct7 = 7'b0000001; funct3 = f3; rs1 = a; rs2 = b;
        if (use4) v4 = 1'b1; else v1 = 1'b1;
        stalls = 0; done = 1'b0; got = '0; sel_seen = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (use4 ? stall4 : stall1) stalls++;
            if (use4 ? mv4 : mv1) begin
                done     = 1'b1;
                got      = use4 ? res4 : res1;
                sel_seen = use4 ? sel4 : sel1;
            end else begin
                @(negedge clk);
                rs1 = $urandom;
                rs2 = $urandom;
            end
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " result"}, got, exp);
        chk({tag, " stall cycles"}, 32'(stalls), 32'(exp_st));
        chk({tag, " md_sel"}, 32'(sel_seen), 32'd1);
        // next instruction is a plain ADD: no stall, no second pulse
        @(negedge clk);
        funct7 = 7'd0; funct3 = 3'd0; alu_op = 3'd0;
        #1;
        chk({tag, " post md_valid"}, 32'(use4 ? mv4 : mv1), 32'd0);
        chk({tag, " post stall"}, 32'(use4 ? stall4 : stall1), 32'd0);
        chk({tag, " post aluop"}, 32'(use4 ? op4 : op1), 32'd0);
        v1 = 1'b0; v4 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; v1 = 1'b0; v4 = 1'b0;
        funct7 = 7'd0; alu_op = 3'd0; funct3 = 3'd0; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset md_valid", 32'({mv1, mv4}), 32'd0);
        chk("reset md_sel", 32'({sel1, sel4}), 32'd0);
        chk("reset result1", res1, 32'd0);
        chk("reset result4", res4, 32'd0);
        // M op presented while reset held low must not stall
        funct7 = 7'b0000001; v1 = 1'b1; v4 = 1'b1;
        #1;
        chk("reset stall", 32'({stall1, stall4}), 32'd0);
        @(negedge clk);
        v1 = 1'b0; v4 = 1'b0; funct7 = 7'd0; reset = 1'b1;

        // 1. decode
        dec(3'b000, 7'b0100000, 3'b000, 4'b0001, "SUB");
        dec(3'b001, 7'b0000000, 3'b110, 4'b0011, "ORI");
        dec(3'b001, 7'b0100000, 3'b101, 4'b0111, "SRAI");
        dec(3'b010, 7'b0000000, 3'b000, 4'b1010, "LUI");
        dec(3'b100, 7'b0000000, 3'b000, 4'b0001, "BRANCH");
        dec(3'b110, 7'b0000000, 3'b011, 4'b0000, "UNDEF");
        for (int i = 0; i < 30; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = 32'($urandom_range(0, 7));
            rb  = $urandom_range(0, 1) ? 32'h20 : 32'h0;
            dec(ra[2:0], rb[6:0], rf3, ref_alu(ra[2:0], rb[6:0], rf3), "rand dec");
        end
        v1 = 1'b0;

        // 2. multiply
        run_m(1'b0, 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, "MUL -3x7");
        run_m(1'b0, 3'd1, MIN, MIN, 32'h4000_0000, "MULH");
        run_m(1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU");
        run_m(1'b0, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "MULHSU");

        // 3. divide
        run_m(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "DIV -7/2");
        run_m(1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "REM -7/2");
        run_m(1'b0, 3'd5, 32'd100, 32'd7, 32'd14, "DIVU 100/7");
        run_m(1'b0, 3'd7, 32'd100, 32'd7, 32'd2, "REMU 100/7");

        // 5. reset during BUSY discards the op
        @(negedge clk);
        alu_op = 3'd0; funct7 = 7'b0000001; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; v1 = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst busy stall", 32'(stall1), 32'd0);
        chk("rst busy md_valid", 32'(mv1), 32'd0);
        chk("rst busy result", res1, 32'd0);
        reset = 1'b1; v1 = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (mv1 || stall1) pulses++;
        end
        chk("rst busy quiet", 32'(pulses), 32'd0);
        run_m(1'b0, 3'd0, 32'd6, 32'd7, 32'd42, "MUL 6x7");

        // valid_i low during BUSY aborts without a result pulse
        @(negedge clk);
        alu_op = 3'd0; funct7 = 7'b0000001; funct3 = 3'd4; rs1 = 32'd50; rs2 = 32'd3; v1 = 1'b1;
        repeat (5) @(negedge clk);
        v1 = 1'b0;
        #1;
        chk("abort stall", 32'(stall1), 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (mv1) pulses++;
        end
        chk("abort no pulse", 32'(pulses), 32'd0);

        // 4. special cases
        run_m(1'b0, 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "DIVU 5/0");
        run_m(1'b0, 3'd6, 32'd5, 32'd0, 32'd5, "REM 5/0");
        run_m(1'b0, 3'd4, MIN, 32'hFFFF_FFFF, MIN, "DIV ovf");
        run_m(1'b0, 3'd6, MIN, 32'hFFFF_FFFF, 32'd0, "REM ovf");

        // randomized ops on the 1-bit/cycle instance
        for (int i = 0; i < 12; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            run_m(1'b0, rf3, ra, rb, ref_md(rf3, ra, rb), "rand md");
        end

        // 6. 4-bit/cycle multiplier instance
        run_m(1'b1, 3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780, "MUL4");
        for (int i = 0; i < 8; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            run_m(1'b1, rf3, ra, rb, ref_md(rf3, ra, rb), "rand md4");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_control_mdu.md
Name: alu_control_mdu

Overview:
Next-generation ALU control for the RISC-V core.
- Decodes {funct7, ALU_Op, funct3} into the 4-bit ALU operation code for all RV32I ops. This path is combinational with zero latency.
- Adds the RV32M extension through an internal iterative multiply/divide sequencer.
- While a MUL/DIV/REM runs, the block stalls the pipeline and then supplies its own result to the writeback mux.
- Sits between the main control unit, the register file read ports and the ALU/writeback mux.

Parameters:
- DATA_WIDTH, 32, operand/result width. Must be even, ≥8.
- MUL_BITS_PER_CYCLE, 1, multiplier bits retired per cycle. Legal values: 1, 2, 4; must divide DATA_WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- valid_i  in  1  instruction present in execute is valid
- funct7_i  in  7  instruction funct7 field
- ALU_Op_i  in  3  class from main control: 000 R, 001 I-arith, 010 LUI, 011 load/store/JALR, 100 branch
- funct3_i  in  3  instruction funct3 field
- rs1_data_i  in  DATA_WIDTH  operand A
- rs2_data_i  in  DATA_WIDTH  operand B
- ALU_Operation_o  out  4  ALU code: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010
- stall_o  out  1  hold PC/pipeline this cycle
- md_sel_o  out  1  writeback takes md_result_o
- md_result_o  out  DATA_WIDTH  M-extension result
- md_valid_o  out  1  single-cycle pulse, result valid

Behaviour:

Decode (combinational):
- R-type: SUB/SRA when funct7[5]=1.
- I-type: SRAI when funct7[5]=1 and funct3=101; other I-type ops ignore funct7.
- LUI→PASSB; 011→ADD; 100→SUB.
- Undefined combinations→ADD.

M op detection:
- is_m = valid_i & ALU_Op_i==000 & funct7_i==0000001.
- funct3 selects: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.

FSM states: IDLE, BUSY, DONE.
- IDLE & is_m:
  - Capture operand magnitudes, sign flags and funct3.
  - Normal case: load counter with N (MUL: DATA_WIDTH/MUL_BITS_PER_CYCLE; DIV/REM: DATA_WIDTH), go to BUSY.
  - Fast path (divisor==0, or signed overflow MIN/−1): skip BUSY and go straight to DONE with the special result.
- BUSY:
  - One iteration per cycle: shift-add multiply, or restoring divide at 1 bit/cycle; counter decrements.
  - Counter==1 at the edge → register the sign-corrected result, go to DONE.
- DONE:
  - md_valid_o=1, md_sel_o=1, stall_o=0.
  - The PC advances on this edge; the FSM returns to IDLE.
  - No relaunch from DONE.

Outputs:
- stall_o = is_m & state!=DONE.
- Occupancy at defaults: MUL 34 cycles (stall 33); DIV 34 cycles; fast path 2 cycles (stall 1).

Results:
- Signed ops run on magnitudes, then correct the sign.
  - Product is negative when the operand signs differ.
  - Quotient is negative when the signs differ; remainder takes the sign of the dividend.
- MULHSU: rs1 signed, rs2 unsigned.
- MULH*: return product[2W-1:W]; MUL returns product[W-1:0].
- Divide by zero: quotient all-ones (DIV and DIVU); remainder = rs1.
- Overflow MIN/−1: DIV returns MIN; REM returns 0.

Boundaries:
- Operand changes during BUSY are ignored; values are captured at accept.
- valid_i low during BUSY: abort, IDLE next edge, no md_valid_o.
- reset low at any edge: IDLE, counter 0, md_result_o=0, md_valid_o=0, md_sel_o=0, stall_o=0. Any in-flight op is discarded.
- While reset is low, stall_o is forced 0.
- ALU_Operation_o is valid regardless of FSM state.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU_Op class encodings
  - ALU_Operation codes
  - M funct3 codes
  - FSM state encoding
  - the M funct7 constant 0000001
- Sub-module md_iter_core holds the shift-add/restoring datapath: accumulator, quotient/remainder registers and the iteration step.
- The FSM, sign handling, fast path and decode stay in the top module.

Test Plan:
1. Decode sweep:
   - SUB (R, funct7 0100000, f3 000) → 0001.
   - ORI (001, f3 110) → 0011.
   - SRAI (001, funct7[5]=1, f3 101) → 0111.
   - LUI (010) → 1010.
   - Expect stall_o=0 throughout.
2. MUL −3×7:
   - Result 0xFFFFFFEB; md_valid_o one pulse; stall_o exactly 33 cycles.
   - MULH 0x80000000×0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
3. Division:
   - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
   - DIVU 100/7 → 14; REMU 100/7 → 2.
   - Each takes 34 cycles.
4. Special cases:
   - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; stall_o 1 cycle.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
5. Reset in BUSY cycle 10:
   - Next cycle: IDLE, stall_o=0, no md_valid_o.
   - A following MUL 6×7 → 42.
6. MUL_BITS_PER_CYCLE=4:
   - MUL 0x12345678×0x10 → 0x23456780 with 8 BUSY cycles.
   - Back-to-back MUL then ADD: the ADD decodes 0000 with no stall.
